// File: rtl/seg7_scan_display.sv
// seg7_scan_display: accepts a binary value over valid/ready, converts it to BCD
// one bit per clock (shift-and-add-3), and drives a single time-multiplexed
// 7-segment bus with one-hot digit select, leading-zero blanking and an
// overflow indication (all digits show a dash).
module seg7_scan_display #(
  parameter int DATA_W   = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     bin_in,
  input  logic                  bin_valid,
  output logic                  bin_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel
);

  // Accumulator holds every decimal digit DATA_W bits can produce, and at
  // least DIGITS digits so the committed slice always exists.
  localparam int NB_CALC = (DATA_W * 302 + 999) / 1000 + 1;
  localparam int NB      = (NB_CALC > DIGITS) ? NB_CALC : DIGITS;
  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Largest value representable in DIGITS decimal digits (10^DIGITS - 1).
  function automatic longint unsigned max_decimal(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int k = 0; k < n; k++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam longint unsigned MAX_VAL = max_decimal(DIGITS);

  // Segment pattern for one BCD digit; seg[0]=a .. seg[6]=g.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_W-1:0]     r_bin;
  logic [4*NB-1:0]       r_bcd;
  logic [4*NB-1:0]       w_adj;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf_pend;
  logic                  w_ovf;
  logic                  w_accept;
  logic                  r_bin_ready;
  logic [4*DIGITS-1:0]   r_bcd_out;
  logic                  r_bcd_valid;
  logic                  r_overflow;
  logic [PRE_W-1:0]      r_pre;
  logic [IDX_W-1:0]      r_idx;
  logic [6:0]            r_seg;
  logic [DIGITS-1:0]     r_dig_sel;
  logic [3:0]            w_digit;
  logic                  w_blank;
  logic                  w_zero_run;
  logic [6:0]            w_seg_nxt;
  logic [DIGITS-1:0]     w_sel_nxt;

  assign w_accept  = (r_state == ST_IDLE) && bin_valid && r_bin_ready;
  assign w_ovf     = (64'(bin_in) > MAX_VAL);
  assign bin_ready = r_bin_ready;
  assign bcd_out   = r_bcd_out;
  assign bcd_valid = r_bcd_valid;
  assign overflow  = r_overflow;
  assign seg       = r_seg;
  assign dig_sel   = r_dig_sel;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: IDLE -> SHIFT on accept, SHIFT for DATA_W cycles, one COMMIT cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_COMMIT;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Add-3 correction on every accumulator nibble that is 5 or more.
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < NB; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end else begin
        w_adj[4*k +: 4] = r_bcd[4*k +: 4];
      end
    end
  end

  // Conversion datapath: capture on accept, then shift one binary bit into the BCD accumulator per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_bin      <= bin_in;
            r_bcd      <= '0;
            r_cnt      <= CNT_W'(DATA_W);
            r_ovf_pend <= w_ovf;
          end
        end
        ST_SHIFT: begin
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt          <= r_cnt - CNT_W'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Committed display registers only change when a conversion completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin_ready <= 1'b1;
      r_bcd_out   <= '0;
      r_bcd_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_bin_ready <= (w_state_nxt == ST_IDLE);
      r_bcd_valid <= (r_state == ST_COMMIT);
      if (r_state == ST_COMMIT) begin
        r_bcd_out  <= r_bcd[4*DIGITS-1:0];
        r_overflow <= r_ovf_pend;
      end
    end
  end

  // Scan prescaler and digit index: advance the index once per SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
      r_pre <= '0;
      if (r_idx == IDX_W'(DIGITS - 1)) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Select the scanned digit, work out leading-zero blanking and the segment pattern.
  always_comb begin
    w_digit    = 4'd0;
    w_blank    = 1'b0;
    w_zero_run = 1'b1;
    w_sel_nxt  = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (r_bcd_out[4*k +: 4] == 4'd0);
      if (r_idx == IDX_W'(k)) begin
        w_digit      = r_bcd_out[4*k +: 4];
        w_blank      = (k != 0) && w_zero_run;
        w_sel_nxt[k] = 1'b1;
      end
    end
    if (r_overflow) begin
      w_seg_nxt = 7'h40;
    end else if ((BLANK_LZ != 0) && w_blank) begin
      w_seg_nxt = 7'h00;
    end else begin
      w_seg_nxt = seg_decode(w_digit);
    end
  end

  // Register the segment bus and digit select so the display pins are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg     <= 7'h00;
      r_dig_sel <= '0;
    end else begin
      r_seg     <= w_seg_nxt;
      r_dig_sel <= w_sel_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: three instances share the input
// stimulus (3 digits blanking, 3 digits no blanking, 2 digits blanking).
module tb_seg7_scan_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bin_in;
  logic       bin_valid;

  logic        a_bin_ready, a_bcd_valid, a_overflow;
  logic [11:0] a_bcd_out;
  logic [6:0]  a_seg;
  logic [2:0]  a_dig_sel;
  logic        b_bin_ready, b_bcd_valid, b_overflow;
  logic [11:0] b_bcd_out;
  logic [6:0]  b_seg;
  logic [2:0]  b_dig_sel;
  logic        c_bin_ready, c_bcd_valid, c_overflow;
  logic [7:0]  c_bcd_out;
  logic [6:0]  c_seg;
  logic [1:0]  c_dig_sel;

  int checks   = 0;
  int failures = 0;
  int lat;
  int rl;
  logic [6:0] sa [3];
  logic [6:0] sb [3];
  logic [6:0] sc [2];

  always #5 clk = ~clk;

  seg7_scan_display #(.DATA_W(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1)) u_a (
    .clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid),
    .bin_ready(a_bin_ready), .bcd_out(a_bcd_out), .bcd_valid(a_bcd_valid),
    .overflow(a_overflow), .seg(a_seg), .dig_sel(a_dig_sel));

  seg7_scan_display #(.DATA_W(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(0)) u_b (
    .clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid),
    .bin_ready(b_bin_ready), .bcd_out(b_bcd_out), .bcd_valid(b_bcd_valid),
    .overflow(b_overflow), .seg(b_seg), .dig_sel(b_dig_sel));

  seg7_scan_display #(.DATA_W(8), .DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(1)) u_c (
    .clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid),
    .bin_ready(c_bin_ready), .bcd_out(c_bcd_out), .bcd_valid(c_bcd_valid),
    .overflow(c_overflow), .seg(c_seg), .dig_sel(c_dig_sel));

  // Pulse bin_valid for one cycle, then return latency (negedges after accept) and bin_ready-low count.
  task automatic convert(input logic [7:0] v, output int lt, output int rlow);
    @(negedge clk);
    bin_in    = v;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    lt   = 0;
    rlow = 0;
    for (int n = 1; n <= 40; n++) begin
      if (a_bin_ready === 1'b0) rlow++;
      if (a_bcd_valid === 1'b1) begin
        lt = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Record the seg value shown for each digit over one full scan frame plus margin.
  task automatic frame();
    for (int i = 0; i < 3; i++) begin
      sa[i] = 7'bx;
      sb[i] = 7'bx;
    end
    for (int i = 0; i < 2; i++) sc[i] = 7'bx;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (a_dig_sel === (3'b001 << i)) sa[i] = a_seg;
        if (b_dig_sel === (3'b001 << i)) sb[i] = b_seg;
      end
      for (int i = 0; i < 2; i++) begin
        if (c_dig_sel === (2'b01 << i)) sc[i] = c_seg;
      end
    end
  endtask

  task automatic test_reset();
    logic [2:0] e3;
    logic [1:0] e2;
    rst = 1'b1;
    bin_valid = 1'b0;
    bin_in = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_seg, b_seg, c_seg} !== 21'h0) begin
      failures++; $display("FAIL rst_seg got=%h exp=0", {a_seg, b_seg, c_seg});
    end
    checks++;
    if ({a_dig_sel, b_dig_sel, c_dig_sel} !== 8'h00) begin
      failures++; $display("FAIL rst_dig_sel got=%h exp=0", {a_dig_sel, b_dig_sel, c_dig_sel});
    end
    checks++;
    if ({a_bin_ready, b_bin_ready, c_bin_ready} !== 3'b111) begin
      failures++; $display("FAIL rst_ready got=%b exp=111", {a_bin_ready, b_bin_ready, c_bin_ready});
    end
    checks++;
    if ({a_bcd_out, b_bcd_out, c_bcd_out} !== 32'h0) begin
      failures++; $display("FAIL rst_bcd_out got=%h exp=0", {a_bcd_out, b_bcd_out, c_bcd_out});
    end
    checks++;
    if ({a_bcd_valid, b_bcd_valid, c_bcd_valid, a_overflow, b_overflow, c_overflow} !== 6'b0) begin
      failures++; $display("FAIL rst_valid_ovf got=%b exp=000000",
        {a_bcd_valid, b_bcd_valid, c_bcd_valid, a_overflow, b_overflow, c_overflow});
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      e3 = 3'b001 << (k / 4);
      e2 = 2'b01 << ((k / 4) % 2);
      checks++;
      if (a_dig_sel !== e3) begin
        failures++; $display("FAIL scan_sel_a k=%0d got=%b exp=%b", k, a_dig_sel, e3);
      end
      checks++;
      if (a_seg !== ((k < 4) ? 7'h3F : 7'h00)) begin
        failures++; $display("FAIL scan_seg_a k=%0d got=%h exp=%h", k, a_seg, (k < 4) ? 7'h3F : 7'h00);
      end
      checks++;
      if (b_seg !== 7'h3F) begin
        failures++; $display("FAIL scan_seg_b k=%0d got=%h exp=3f", k, b_seg);
      end
      checks++;
      if (c_dig_sel !== e2 || c_seg !== ((e2 == 2'b01) ? 7'h3F : 7'h00)) begin
        failures++; $display("FAIL scan_c k=%0d got=%b/%h exp=%b", k, c_dig_sel, c_seg, e2);
      end
    end
  endtask

  task automatic test_255();
    logic [6:0] ea [3];
    ea[0] = 7'h6D; ea[1] = 7'h6D; ea[2] = 7'h5B;
    convert(8'd255, lat, rl);
    checks++;
    if (lat !== 10) begin failures++; $display("FAIL lat_255 got=%0d exp=10", lat); end
    checks++;
    if (rl !== 9) begin failures++; $display("FAIL ready_low_255 got=%0d exp=9", rl); end
    checks++;
    if (a_bcd_out !== 12'h255 || a_overflow !== 1'b0) begin
      failures++; $display("FAIL bcd_255 got=%h ovf=%b exp=255 ovf=0", a_bcd_out, a_overflow);
    end
    checks++;
    if (c_bcd_out !== 8'h55 || c_overflow !== 1'b1) begin
      failures++; $display("FAIL bcd_255_c got=%h ovf=%b exp=55 ovf=1", c_bcd_out, c_overflow);
    end
    frame();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sa[i] !== ea[i]) begin failures++; $display("FAIL seg_255 d%0d got=%h exp=%h", i, sa[i], ea[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (sc[i] !== 7'h40) begin failures++; $display("FAIL seg_255_c d%0d got=%h exp=40", i, sc[i]); end
    end
  endtask

  task automatic test_blank();
    logic [6:0] ea [3];
    logic [6:0] eb [3];
    ea[0] = 7'h07; ea[1] = 7'h00; ea[2] = 7'h00;
    eb[0] = 7'h07; eb[1] = 7'h3F; eb[2] = 7'h3F;
    convert(8'd7, lat, rl);
    checks++;
    if (a_bcd_out !== 12'h007) begin failures++; $display("FAIL bcd_7 got=%h exp=007", a_bcd_out); end
    frame();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sa[i] !== ea[i]) begin failures++; $display("FAIL seg_7_blank d%0d got=%h exp=%h", i, sa[i], ea[i]); end
      checks++;
      if (sb[i] !== eb[i]) begin failures++; $display("FAIL seg_7_noblank d%0d got=%h exp=%h", i, sb[i], eb[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [6:0] ea [3];
    ea[0] = 7'h3F; ea[1] = 7'h3F; ea[2] = 7'h06;
    convert(8'd100, lat, rl);
    checks++;
    if (c_overflow !== 1'b1 || c_bcd_out !== 8'h00) begin
      failures++; $display("FAIL ovf_100 got=%b/%h exp=1/00", c_overflow, c_bcd_out);
    end
    checks++;
    if (a_overflow !== 1'b0 || a_bcd_out !== 12'h100) begin
      failures++; $display("FAIL bcd_100 got=%b/%h exp=0/100", a_overflow, a_bcd_out);
    end
    frame();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (sc[i] !== 7'h40) begin failures++; $display("FAIL seg_100_c d%0d got=%h exp=40", i, sc[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sa[i] !== ea[i]) begin failures++; $display("FAIL seg_100 d%0d got=%h exp=%h", i, sa[i], ea[i]); end
    end
    convert(8'd42, lat, rl);
    checks++;
    if (c_overflow !== 1'b0 || c_bcd_out !== 8'h42) begin
      failures++; $display("FAIL bcd_42_c got=%b/%h exp=0/42", c_overflow, c_bcd_out);
    end
    frame();
    checks++;
    if (sc[0] !== 7'h5B || sc[1] !== 7'h66) begin
      failures++; $display("FAIL seg_42_c got=%h,%h exp=5b,66", sc[0], sc[1]);
    end
  endtask

  task automatic test_back_to_back();
    int lat1 = 0;
    int lat2 = 0;
    int bad  = 0;
    @(negedge clk);
    bin_in    = 8'd12;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_in = 8'd34;
    for (int n = 1; n <= 40; n++) begin
      if (a_bcd_valid === 1'b1) begin lat1 = n; break; end
      @(negedge clk);
    end
    checks++;
    if (lat1 !== 10 || a_bcd_out !== 12'h012) begin
      failures++; $display("FAIL b2b_first got lat=%0d bcd=%h exp lat=10 bcd=012", lat1, a_bcd_out);
    end
    checks++;
    if (a_bin_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_at_valid got=%b exp=1", a_bin_ready); end
    @(negedge clk);
    bin_valid = 1'b0;
    checks++;
    if (a_bin_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept got ready=%b exp=0", a_bin_ready); end
    for (int n = 1; n <= 40; n++) begin
      if (a_bcd_valid === 1'b1) begin lat2 = n; break; end
      if (a_bcd_out !== 12'h012) bad++;
      @(negedge clk);
    end
    checks++;
    if (lat2 !== 10 || a_bcd_out !== 12'h034) begin
      failures++; $display("FAIL b2b_second got lat=%0d bcd=%h exp lat=10 bcd=034", lat2, a_bcd_out);
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL b2b_no_partial got=%0d exp=0", bad); end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    logic [6:0] ea [3];
    ea[0] = 7'h6F; ea[1] = 7'h00; ea[2] = 7'h00;
    frame();
    @(negedge clk);
    bin_in    = 8'd200;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (a_bcd_valid === 1'b1) pulses++;
    end
    checks++;
    if (a_bin_ready !== 1'b1 || a_bcd_out !== 12'h000 || a_seg !== 7'h00 || a_dig_sel !== 3'b000 ||
        a_overflow !== 1'b0) begin
      failures++; $display("FAIL abort_reset_vals got rdy=%b bcd=%h seg=%h sel=%b ovf=%b exp 1/000/00/000/0",
        a_bin_ready, a_bcd_out, a_seg, a_dig_sel, a_overflow);
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (a_bcd_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL abort_no_valid got=%0d exp=0", pulses); end
    convert(8'd9, lat, rl);
    checks++;
    if (lat !== 10 || a_bcd_out !== 12'h009) begin
      failures++; $display("FAIL after_abort got lat=%0d bcd=%h exp lat=10 bcd=009", lat, a_bcd_out);
    end
    frame();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sa[i] !== ea[i]) begin failures++; $display("FAIL seg_9 d%0d got=%h exp=%h", i, sa[i], ea[i]); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    bin_valid = 1'b0;
    bin_in    = 8'd0;
    test_reset();
    test_255();
    test_blank();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
